ctrl_fsm_mc: RTL

- Parametrised multicycle control unit for the MIPS-subset datapath.
- Next generation of the single-path FETCH controller. Adds:
  - full decode of a fixed instruction subset;
  - configurable memory wait states;
  - a start/done handshake with the multi-cycle mul/div unit;
  - optional exception entry.
- Sits between the instruction register (opcode/funct) and every datapath mux and write enable.

---
 rtl/ctrl_fsm_mc.sv | 328 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_fsm_mc.sv
// ctrl_fsm_mc: multicycle control unit for the MIPS-subset datapath.
// Decodes opcode/funct from the instruction register and drives every datapath
// mux select and write enable. Outputs are a Moore decode of the state register.
// They are held in a register that is loaded with the decode of the next state.
//
// Parameters:
//   MEM_WAIT  extra memory wait cycles after mem_read (0..15)
//   WAIT_W    width of the wait counter, must hold MEM_WAIT
// Optional feature macro: CTRL_FSM_MC_EXC_EN (exception entry on unsupported
//   encodings, ALU overflow on add/sub/addi, divide by zero).
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   opcode, funct                  IR[31:26], IR[5:0]
//   alu_ovf, md_done, md_div0      datapath status inputs
//   pc_write .. reg_dst            datapath control outputs
//   state_o                        current state for debug
//
// State encoding on state_o:
//   0 RESET, 1 FETCH, 2 FETCH_DONE, 3 DECODE, 4 EXEC_R, 5 WB_R, 6 EXEC_I,
//   7 WB_I, 8 ADDR, 9 MEM_RD, 10 WB_LOAD, 11 MEM_WR, 12 BRANCH, 13 JUMP,
//   14 JAL, 15 JR, 16 MD_START, 17 MD_WAIT, 18 MD_WB, 19 WB_MD, 20 EXC
module ctrl_fsm_mc #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_ovf,
    input  logic       md_done,
    input  logic       md_div0,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       mem_read,
    output logic       mem_write,
    output logic       byte_or_word,
    output logic       ir_write,
    output logic       reg_write,
    output logic       div_mul_wr,
    output logic       div_mul_to_reg,
    output logic       epc_write,
    output logic       md_start,
    output logic       md_op,
    output logic [1:0] i_or_d,
    output logic [2:0] mem_to_reg,
    output logic [2:0] pc_src,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] reg_dst,
    output logic [4:0] state_o
);

`ifdef CTRL_FSM_MC_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_DONE = 5'd2,
        S_DECODE     = 5'd3,
        S_EXEC_R     = 5'd4,
        S_WB_R       = 5'd5,
        S_EXEC_I     = 5'd6,
        S_WB_I       = 5'd7,
        S_ADDR       = 5'd8,
        S_MEM_RD     = 5'd9,
        S_WB_LOAD    = 5'd10,
        S_MEM_WR     = 5'd11,
        S_BRANCH     = 5'd12,
        S_JUMP       = 5'd13,
        S_JAL        = 5'd14,
        S_JR         = 5'd15,
        S_MD_START   = 5'd16,
        S_MD_WAIT    = 5'd17,
        S_MD_WB      = 5'd18,
        S_WB_MD      = 5'd19,
        S_EXC        = 5'd20
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       mem_read;
        logic       mem_write;
        logic       byte_or_word;
        logic       ir_write;
        logic       reg_write;
        logic       div_mul_wr;
        logic       div_mul_to_reg;
        logic       epc_write;
        logic       md_start;
        logic       md_op;
        logic [1:0] i_or_d;
        logic [2:0] mem_to_reg;
        logic [2:0] pc_src;
        logic [2:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] reg_dst;
    } ctrl_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    ctrl_t             ctrl_q, ctrl_next;

    // Moore output decode for one state; opcode/funct are stable from DECODE on.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op,
                                          input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1;
            end
            S_FETCH_DONE: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_EXEC_R: begin
                c.alu_src_a = 2'b01;
                c.alu_op    = (fn == FN_SUB) ? 3'b001 :
                              (fn == FN_AND) ? 3'b010 : 3'b000;
            end
            S_WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
            end
            S_EXEC_I, S_ADDR: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            S_WB_I: begin
                c.reg_write = 1'b1;
            end
            S_MEM_RD: begin
                c.mem_read     = 1'b1;
                c.i_or_d       = 2'b01;
                c.byte_or_word = (op == OP_LB);
            end
            S_WB_LOAD: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 3'b001;
            end
            S_MEM_WR: begin
                c.mem_write    = 1'b1;
                c.i_or_d       = 2'b01;
                c.byte_or_word = (op == OP_SB);
            end
            S_BRANCH: begin
                c.pc_write_cond = 1'b1;
                c.branch_ne     = (op == OP_BNE);
                c.alu_op        = 3'b001;
                c.alu_src_a     = 2'b01;
                c.pc_src        = 3'b001;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 3'b010;
            end
            S_JAL: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 3'b100;
            end
            S_JR: begin
                c.pc_write = 1'b1;
                c.pc_src   = 3'b011;
            end
            S_MD_START: begin
                c.md_start = 1'b1;
                c.md_op    = (fn == FN_DIV);
            end
            S_MD_WB: begin
                c.div_mul_wr = 1'b1;
            end
            S_WB_MD: begin
                c.reg_write      = 1'b1;
                c.reg_dst        = 2'b01;
                c.div_mul_to_reg = 1'b1;
                c.mem_to_reg     = (fn == FN_MFLO) ? 3'b011 : 3'b010;
            end
            S_EXC: begin
                // Unreachable without exception support; keeps epc_write at 0.
                if (EXC_EN) begin
                    c.epc_write = 1'b1;
                    c.pc_write  = 1'b1;
                    c.pc_src    = 3'b100;
                end
            end
            default: ;
        endcase
        return c;
    endfunction

    // State, wait counter and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RESET;
            wait_cnt <= '0;
            ctrl_q   <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            ctrl_q   <= ctrl_next;
        end
    end

    // Next-state, wait counter and next-output decode.
    always_comb begin
        state_next = state;
        wait_next  = '0;
        ctrl_next  = '0;

        case (state)
            S_RESET:      state_next = S_FETCH;
            S_FETCH: begin
                if (wait_cnt == '0) begin
                    state_next = S_FETCH_DONE;
                end else begin
                    wait_next = wait_cnt - WAIT_W'(1);
                end
            end
            S_FETCH_DONE: state_next = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_RTYPE) begin
                    case (funct)
                        FN_ADD, FN_SUB, FN_AND: state_next = S_EXEC_R;
                        FN_JR:                  state_next = S_JR;
                        FN_MULT, FN_DIV:        state_next = S_MD_START;
                        FN_MFHI, FN_MFLO:       state_next = S_WB_MD;
                        default:                state_next = EXC_EN ? S_EXC : S_FETCH;
                    endcase
                end else begin
                    case (opcode)
                        OP_ADDI:                   state_next = S_EXEC_I;
                        OP_LW, OP_SW, OP_LB, OP_SB: state_next = S_ADDR;
                        OP_BEQ, OP_BNE:            state_next = S_BRANCH;
                        OP_J:                      state_next = S_JUMP;
                        OP_JAL:                    state_next = S_JAL;
                        default:                   state_next = EXC_EN ? S_EXC : S_FETCH;
                    endcase
                end
            end
            // 'and' cannot overflow, so only add/sub trap.
            S_EXEC_R:     state_next = (EXC_EN && alu_ovf && funct != FN_AND) ? S_EXC : S_WB_R;
            S_EXEC_I:     state_next = (EXC_EN && alu_ovf) ? S_EXC : S_WB_I;
            S_ADDR:       state_next = (opcode == OP_LW || opcode == OP_LB) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (wait_cnt == '0) begin
                    state_next = S_WB_LOAD;
                end else begin
                    wait_next = wait_cnt - WAIT_W'(1);
                end
            end
            S_JAL:        state_next = S_JUMP;
            // md_done in this cycle belongs to a previous operation; never sampled here.
            S_MD_START:   state_next = (EXC_EN && md_div0 && funct == FN_DIV) ? S_EXC : S_MD_WAIT;
            S_MD_WAIT:    state_next = md_done ? S_MD_WB : S_MD_WAIT;
            S_WB_R, S_WB_I, S_WB_LOAD, S_MEM_WR, S_BRANCH, S_JUMP, S_JR,
            S_MD_WB, S_WB_MD, S_EXC:
                          state_next = S_FETCH;
            default:      state_next = S_FETCH;
        endcase

        // Entering a wait state loads the full wait count.
        if ((state_next == S_FETCH && state != S_FETCH) ||
            (state_next == S_MEM_RD && state != S_MEM_RD)) begin
            wait_next = WAIT_W'(MEM_WAIT);
        end

        ctrl_next = decode_ctrl(state_next, opcode, funct);
    end

    assign pc_write       = ctrl_q.pc_write;
    assign pc_write_cond  = ctrl_q.pc_write_cond;
    assign branch_ne      = ctrl_q.branch_ne;
    assign mem_read       = ctrl_q.mem_read;
    assign mem_write      = ctrl_q.mem_write;
    assign byte_or_word   = ctrl_q.byte_or_word;
    assign ir_write       = ctrl_q.ir_write;
    assign reg_write      = ctrl_q.reg_write;
    assign div_mul_wr     = ctrl_q.div_mul_wr;
    assign div_mul_to_reg = ctrl_q.div_mul_to_reg;
    assign epc_write      = ctrl_q.epc_write;
    assign md_start       = ctrl_q.md_start;
    assign md_op          = ctrl_q.md_op;
    assign i_or_d         = ctrl_q.i_or_d;
    assign mem_to_reg     = ctrl_q.mem_to_reg;
    assign pc_src         = ctrl_q.pc_src;
    assign alu_op         = ctrl_q.alu_op;
    assign alu_src_a      = ctrl_q.alu_src_a;
    assign alu_src_b      = ctrl_q.alu_src_b;
    assign reg_dst        = ctrl_q.reg_dst;
    assign state_o        = state;

endmodule
